// File: rtl/eth_pkg.sv
// Shared constants, CRC-32 parameters and FSM state type
// for the Ethernet preamble stripper.
package eth_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

   typedef enum logic [1:0] {
      HUNT,
      PREAMBLE,
      PAYLOAD,
      DROP
   } state_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational reflected CRC-32 update by one byte
// (LSB-first, no final inversion).
import eth_pkg::*;

module eth_crc32_byte (
   input  logic [31:0] i_crc,
   input  logic [7:0]  i_data,
   output logic [31:0] o_crc
);

   logic [31:0] w_c;

   always_comb begin
      w_c = i_crc ^ {24'h0, i_data};
      for (int i = 0; i < 8; i++) begin
         w_c = w_c[0] ? ((w_c >> 1) ^ CRC32_POLY) : (w_c >> 1);
      end
      o_crc = w_c;
   end

endmodule

// File: rtl/strip_preamble.sv
// Strips preamble/SFD from an AXI-Stream byte stream; define
// STRIP_PREAMBLE_FCS_CHECK_EN to hold back and verify the 4-byte FCS.
import eth_pkg::*;

module strip_preamble #(
   parameter int MIN_PREAMBLE_BYTES = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] saxis_tdata,
   input  logic       saxis_tvalid,
   output logic       saxis_tready,
   input  logic       saxis_tlast,
   input  logic       saxis_tuser,
   output logic [7:0] maxis_tdata,
   output logic       maxis_tvalid,
   input  logic       maxis_tready,
   output logic       maxis_tlast,
   output logic       maxis_tuser,
   output logic       frame_dropped
);

   state_t     r_state;
   logic [7:0] r_cnt;
   logic       r_drop;
   logic       r_mvalid;
   logic [7:0] r_mdata;
   logic       r_mlast;
   logic       r_muser;
   logic       w_acc;
   logic       w_is_pre;
   logic       w_is_sfd;

`ifdef STRIP_PREAMBLE_FCS_CHECK_EN
   logic [31:0] r_fcs;
   logic [2:0]  r_fcnt;
   logic [31:0] r_crc;
   logic [31:0] w_crc_next;

   eth_crc32_byte u_crc (
      .i_crc  (r_crc),
      .i_data (saxis_tdata),
      .o_crc  (w_crc_next)
   );
`endif

   // Outside PAYLOAD nothing is emitted, so input is never stalled.
   assign saxis_tready = (r_state != PAYLOAD) || !r_mvalid || maxis_tready;
   assign w_acc        = saxis_tvalid && saxis_tready;
   assign w_is_pre     = (saxis_tdata == PREAMBLE_BYTE);
   assign w_is_sfd     = (saxis_tdata == SFD_BYTE);

   assign maxis_tdata   = r_mdata;
   assign maxis_tvalid  = r_mvalid;
   assign maxis_tlast   = r_mlast;
   assign maxis_tuser   = r_muser;
   assign frame_dropped = r_drop;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= HUNT;
         r_cnt    <= 8'd0;
         r_drop   <= 1'b0;
         r_mvalid <= 1'b0;
         r_mdata  <= 8'h00;
         r_mlast  <= 1'b0;
         r_muser  <= 1'b0;
`ifdef STRIP_PREAMBLE_FCS_CHECK_EN
         r_fcs    <= 32'h0;
         r_fcnt   <= 3'd0;
         r_crc    <= CRC32_INIT;
`endif
      end else begin
         r_drop <= 1'b0;
         if (r_mvalid && maxis_tready) begin
            r_mvalid <= 1'b0;
         end
         if (w_acc) begin
            unique case (r_state)
               HUNT: begin
                  if (saxis_tlast) begin
                     r_drop <= 1'b1;
                  end else if (w_is_pre) begin
                     r_state <= PREAMBLE;
                     r_cnt   <= 8'd1;
                  end else begin
                     r_state <= DROP;
                     r_drop  <= 1'b1;
                  end
               end
               PREAMBLE: begin
                  if (saxis_tlast) begin
                     r_state <= HUNT;
                     r_drop  <= 1'b1;
                  end else if (w_is_pre) begin
                     if (r_cnt != 8'hFF) begin
                        r_cnt <= r_cnt + 8'd1;
                     end
                  end else if (w_is_sfd &&
                               (int'(r_cnt) >= MIN_PREAMBLE_BYTES)) begin
                     r_state <= PAYLOAD;
`ifdef STRIP_PREAMBLE_FCS_CHECK_EN
                     r_crc   <= CRC32_INIT;
                     r_fcnt  <= 3'd0;
`endif
                  end else begin
                     r_state <= DROP;
                     r_drop  <= 1'b1;
                  end
               end
               PAYLOAD: begin
`ifdef STRIP_PREAMBLE_FCS_CHECK_EN
                  // r_fcs[7:0] is the oldest byte held back.
                  r_crc <= w_crc_next;
                  r_fcs <= {saxis_tdata, r_fcs[31:8]};
                  if (r_fcnt == 3'd4) begin
                     r_mvalid <= 1'b1;
                     r_mdata  <= r_fcs[7:0];
                     r_mlast  <= saxis_tlast;
                     r_muser  <= saxis_tlast &&
                                 (saxis_tuser ||
                                  (w_crc_next != CRC32_RESIDUE));
                  end else begin
                     r_fcnt <= r_fcnt + 3'd1;
                  end
                  if (saxis_tlast) begin
                     r_state <= HUNT;
                     r_fcnt  <= 3'd0;
                     if (r_fcnt != 3'd4) begin
                        r_drop <= 1'b1;
                     end
                  end
`else
                  r_mvalid <= 1'b1;
                  r_mdata  <= saxis_tdata;
                  r_mlast  <= saxis_tlast;
                  r_muser  <= saxis_tlast && saxis_tuser;
                  if (saxis_tlast) begin
                     r_state <= HUNT;
                  end
`endif
               end
               DROP: begin
                  if (saxis_tlast) begin
                     r_state <= HUNT;
                  end
               end
               default: r_state <= HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_strip_preamble.sv
// Directed and random bench for strip_preamble; selects the FCS
// vectors when STRIP_PREAMBLE_FCS_CHECK_EN is defined.
module tb_strip_preamble;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] sd = 8'h00;
   logic       sv = 1'b0, sl = 1'b0, su = 1'b0;
   logic       s_tready;
   logic [7:0] md;
   logic       mv, ml, mu, fd;
   logic       mr = 1'b1;

   logic [7:0] s2d = 8'h00;
   logic       s2v = 1'b0, s2l = 1'b0, s2u = 1'b0;
   logic       s2r;
   logic [7:0] m2d;
   logic       m2v, m2l, m2u, fd2;
   logic       m2r = 1'b1;

   int         checks = 0;
   int         errors = 0;
   int         drops  = 0;
   int         drops2 = 0;
   int         v2cnt  = 0;
   int         d0;
   int         v0;
   logic [9:0] last2;
   logic [9:0] q[$];
   logic [9:0] hold_d;
   logic [9:0] exp_e;
   bit         hold_p = 0;
   bit         mon_en = 1;
   bit         rnd = 0;
   logic [7:0] pl [0:31];

   always #5 clock = ~clock;

   strip_preamble #(.MIN_PREAMBLE_BYTES(1)) dut (
      .clock(clock), .reset(reset),
      .saxis_tdata(sd), .saxis_tvalid(sv), .saxis_tready(s_tready),
      .saxis_tlast(sl), .saxis_tuser(su),
      .maxis_tdata(md), .maxis_tvalid(mv), .maxis_tready(mr),
      .maxis_tlast(ml), .maxis_tuser(mu), .frame_dropped(fd)
   );

   strip_preamble #(.MIN_PREAMBLE_BYTES(2)) dut2 (
      .clock(clock), .reset(reset),
      .saxis_tdata(s2d), .saxis_tvalid(s2v), .saxis_tready(s2r),
      .saxis_tlast(s2l), .saxis_tuser(s2u),
      .maxis_tdata(m2d), .maxis_tvalid(m2v), .maxis_tready(m2r),
      .maxis_tlast(m2l), .maxis_tuser(m2u), .frame_dropped(fd2)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output monitor: random backpressure, hold stability, queue model.
   always @(negedge clock) begin
      mr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (fd) drops++;
      if (fd2) drops2++;
      if (m2v) begin
         v2cnt++;
         last2 = {m2l, m2u, m2d};
      end
      if (mon_en) begin
         if (hold_p) chk("hold", {mv, ml, mu, md}, {1'b1, hold_d});
         if (mv && mr) begin
            chk("out_avail", (q.size() != 0), 1'b1);
            if (q.size() != 0) begin
               exp_e = q.pop_front();
               chk("out", {ml, mu, md}, exp_e);
            end
         end
         hold_p = mv && !mr;
         hold_d = {ml, mu, md};
      end else begin
         hold_p = 0;
      end
   end

   task automatic send(input logic [7:0] d, input logic l, input logic u);
      int n;
      n = 0;
      @(negedge clock);
      sd = d; sv = 1'b1; sl = l; su = u;
      #1;
      while (!s_tready && n < 1000) begin
         @(negedge clock);
         #1;
         n++;
      end
      if (!s_tready) chk("tready_timeout", s_tready, 1'b1);
      @(posedge clock);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clock);
         sv = 1'b0; sl = 1'b0; su = 1'b0;
      end
   endtask

   task automatic send_frame(input int npre, input int len, input logic u,
                             input int nexp, input logic uexp);
      for (int i = 0; i < nexp; i++) begin
         q.push_back({(i == nexp - 1), (i == nexp - 1) && uexp, pl[i]});
      end
      for (int i = 0; i < npre; i++) send(8'h55, 1'b0, 1'b0);
      send(8'hD5, 1'b0, 1'b0);
      for (int i = 0; i < len; i++) begin
         send(pl[i], (i == len - 1), (i == len - 1) && u);
      end
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      idle(1);
      while ((q.size() != 0 || mv) && n < 500) begin
         @(negedge clock);
         #2;
         n++;
      end
      chk({tag, "_drain"}, q.size(), 0);
      idle(2);
   endtask

   task automatic send2(input logic [7:0] d, input logic l);
      @(negedge clock);
      s2d = d; s2v = 1'b1; s2l = l; s2u = 1'b0;
      #1;
      chk("t2_ready", s2r, 1'b1);
   endtask

   task automatic idle2(input int n);
      repeat (n) begin
         @(negedge clock);
         s2v = 1'b0; s2l = 1'b0;
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      chk("rst_mvalid", mv, 1'b0);
      chk("rst_mdata", md, 8'h00);
      chk("rst_mlast", ml, 1'b0);
      chk("rst_muser", mu, 1'b0);
      chk("rst_drop", fd, 1'b0);
      chk("rst_tready", s_tready, 1'b1);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      idle(2);

`ifdef STRIP_PREAMBLE_FCS_CHECK_EN
      pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03; pl[3] = 8'h04;
      pl[4] = 8'hCD; pl[5] = 8'hFB; pl[6] = 8'h3C; pl[7] = 8'hB6;
      d0 = drops;
      send_frame(7, 8, 1'b0, 4, 1'b0);
      drain("fcs_good");
      chk("fcs_good_drops", drops - d0, 0);

      pl[7] = 8'hB7;
      send_frame(7, 8, 1'b0, 4, 1'b1);
      drain("fcs_bad");

      pl[7] = 8'hB6;
      rnd = 1;
      send_frame(3, 8, 1'b1, 4, 1'b1);
      drain("fcs_uerr_bp");
      rnd = 0;

      d0 = drops;
      send_frame(7, 4, 1'b0, 0, 1'b0);
      drain("fcs_short");
      chk("fcs_short_drops", drops - d0, 1);
`else
      // Basic frame
      pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
      d0 = drops;
      send_frame(7, 3, 1'b0, 3, 1'b0);
      drain("basic");
      chk("basic_drops", drops - d0, 0);

      // Bad preamble then good frame
      d0 = drops;
      send(8'h55, 1'b0, 1'b0);
      send(8'h55, 1'b0, 1'b0);
      send(8'hAA, 1'b0, 1'b0);
      send(8'h11, 1'b1, 1'b0);
      pl[0] = 8'h7E;
      send_frame(1, 1, 1'b0, 1, 1'b0);
      drain("badpre");
      chk("badpre_drops", drops - d0, 1);

      // tlast on SFD
      d0 = drops;
      send(8'h55, 1'b0, 1'b0);
      send(8'hD5, 1'b1, 1'b0);
      drain("sfdlast");
      chk("sfdlast_drops", drops - d0, 1);

      // tuser propagates to last byte
      pl[0] = 8'hA0; pl[1] = 8'hA1;
      send_frame(2, 2, 1'b1, 2, 1'b1);
      drain("tuser");

      // MIN_PREAMBLE_BYTES = 2
      d0 = drops2; v0 = v2cnt;
      send2(8'h55, 1'b0);
      send2(8'hD5, 1'b0);
      send2(8'h01, 1'b1);
      idle2(3);
      chk("min2_short_drops", drops2 - d0, 1);
      chk("min2_short_out", v2cnt - v0, 0);
      d0 = drops2; v0 = v2cnt;
      send2(8'h55, 1'b0);
      send2(8'h55, 1'b0);
      send2(8'hD5, 1'b0);
      send2(8'hAB, 1'b1);
      idle2(3);
      chk("min2_ok_drops", drops2 - d0, 0);
      chk("min2_ok_out", v2cnt - v0, 1);
      chk("min2_ok_byte", last2, {1'b1, 1'b0, 8'hAB});

      // Long preamble saturates the count
      pl[0] = 8'h3C;
      send_frame(300, 1, 1'b0, 1, 1'b0);
      drain("longpre");

      // Random frames under random backpressure
      d0 = drops;
      rnd = 1;
      for (int f = 0; f < 200; f++) begin
         int len;
         logic u;
         len = $urandom_range(1, 24);
         u = 1'($urandom_range(0, 1));
         for (int i = 0; i < len; i++) pl[i] = 8'($urandom_range(0, 255));
         send_frame($urandom_range(1, 8), len, u, len, u);
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      drain("random");
      rnd = 0;
      chk("random_drops", drops - d0, 0);

      // Reset during payload byte 3
      mon_en = 0;
      for (int i = 0; i < 7; i++) send(8'h55, 1'b0, 1'b0);
      send(8'hD5, 1'b0, 1'b0);
      send(8'h01, 1'b0, 1'b0);
      send(8'h02, 1'b0, 1'b0);
      @(negedge clock);
      sd = 8'h03; sv = 1'b1; sl = 1'b0; reset = 1'b1;
      #1;
      chk("mrst_mvalid", mv, 1'b0);
      chk("mrst_mdata", md, 8'h00);
      chk("mrst_mlast", ml, 1'b0);
      chk("mrst_muser", mu, 1'b0);
      chk("mrst_drop", fd, 1'b0);
      @(negedge clock);
      reset = 1'b0; sv = 1'b0;
      q.delete();
      idle(1);
      mon_en = 1;
      d0 = drops;
      for (int i = 0; i < 7; i++) send(8'(4 + i), (i == 6), 1'b0);
      idle(3);
      chk("mrst_tail_drops", drops - d0, 1);
      for (int i = 0; i < 10; i++) pl[i] = 8'(8'h20 + i);
      send_frame(7, 10, 1'b0, 10, 1'b0);
      drain("mrst_clean");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/strip_preamble.md
STRIP_PREAMBLE -- requirements
Module: strip_preamble

Interface
REQ-001 SHALL have parameter MIN_PREAMBLE_BYTES, default 1, meaning the minimum count of 0x55 bytes required before the start-of-frame delimiter (SFD).
REQ-002 SHALL have port clock, input, 1, the single clock for all logic.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port saxis_tdata, input, 8, a received byte (preamble, SFD, payload and optional FCS).
REQ-005 SHALL have ports saxis_tvalid (input, 1), saxis_tready (output, 1) and saxis_tlast (input, 1) forming the upstream handshake.
REQ-006 SHALL have port saxis_tuser, input, 1, receive error, sampled with tlast.
REQ-007 SHALL have port maxis_tdata, output, 8, a payload byte.
REQ-008 SHALL have ports maxis_tvalid (output, 1), maxis_tready (input, 1) and maxis_tlast (output, 1) forming the downstream handshake.
REQ-009 SHALL have port maxis_tuser, output, 1, frame error, meaningful only on tlast.
REQ-010 SHALL have port frame_dropped, output, 1, a single-cycle pulse for each discarded frame.

Function
REQ-011 SHALL use a state machine with states HUNT, PREAMBLE, PAYLOAD and DROP.
REQ-012 In HUNT, PREAMBLE and DROP, saxis_tready SHALL be 1, and input bytes SHALL be consumed and never emitted.
REQ-013 Transitions SHALL be as follows.
- HUNT: 0x55 -> PREAMBLE with count = 1.
- HUNT: any other byte -> DROP.
- PREAMBLE: 0x55 -> count++, with count saturating at 255.
- PREAMBLE: 0xD5 with count >= MIN_PREAMBLE_BYTES -> PAYLOAD.
- PREAMBLE: any other byte, or 0xD5 with count too low -> DROP.
- DROP: tlast -> HUNT.
REQ-014 When tlast arrives with a byte accepted in HUNT or PREAMBLE (including the SFD), the frame SHALL be discarded, frame_dropped SHALL pulse, and the state SHALL return to HUNT.
REQ-015 On entry to DROP from a non-tlast byte, frame_dropped SHALL pulse exactly once per frame.
REQ-016 The output SHALL be a single register stage (maxis_tvalid/tdata/tlast/tuser), and in PAYLOAD saxis_tready SHALL equal !maxis_tvalid || maxis_tready.
REQ-017 The output register SHALL hold its data stable while maxis_tvalid && !maxis_tready, with no loss, duplication or reordering under arbitrary backpressure.
REQ-018 Without FCS checking, latency SHALL be 1 cycle from input handshake to maxis_tvalid.
REQ-019 Without FCS checking, the output byte carrying input tlast SHALL have maxis_tlast = 1 and maxis_tuser = saxis_tuser, and the state SHALL return to HUNT.
REQ-020 A new frame's preamble SHALL be accepted on the cycle after the previous tlast is consumed, even if the final output byte is still pending.

Reset
REQ-021 Asserting reset SHALL force the state to HUNT, clear the preamble count and the FCS buffer, load the CRC with its init value, and drive maxis_tvalid, maxis_tlast, maxis_tuser and frame_dropped to 0 and maxis_tdata to 0x00.
REQ-022 After reset is released mid-frame, the remainder of that frame SHALL be treated as a new frame attempt: the first non-0x55 byte enters DROP.

Configuration
REQ-023 Macro STRIP_PREAMBLE_FCS_CHECK_EN SHALL control FCS handling.
REQ-024 When STRIP_PREAMBLE_FCS_CHECK_EN is undefined, all post-SFD bytes SHALL be passed through as payload.
REQ-025 When STRIP_PREAMBLE_FCS_CHECK_EN is defined, a 4-byte delay buffer SHALL be inserted, and a payload byte SHALL be emitted only when a 5th post-SFD byte arrives behind it.
REQ-026 With FCS checking, the last 4 bytes (the FCS) SHALL never be emitted.
REQ-027 With FCS checking, the CRC-32 SHALL be the reflected form with polynomial 0xEDB88320 and init 0xFFFFFFFF, updated over every post-SFD byte including the FCS.
REQ-028 With FCS checking, at input tlast the last emitted byte SHALL carry maxis_tlast = 1 and maxis_tuser = saxis_tuser || (crc != 0xDEBB20E3).
REQ-029 With FCS checking, a frame with 4 or fewer post-SFD bytes SHALL emit nothing and SHALL pulse frame_dropped.
REQ-030 With FCS checking, latency SHALL be 1 cycle after the enabling 5th byte.

Structure
REQ-031 Package eth_pkg SHALL hold PREAMBLE_BYTE (0x55), SFD_BYTE (0xD5), CRC32_POLY, CRC32_INIT, CRC32_RESIDUE and the state enum typedef.
REQ-032 The sub-module eth_crc32_byte SHALL be a combinational next-CRC-from-byte function, instantiated only under STRIP_PREAMBLE_FCS_CHECK_EN.

Verification
REQ-033 Stimulus 55x7, D5, 01 02 03 (tlast on 03, tuser 0), macro off -> output 01 02 03 with tlast on 03 and tuser 0, and frame_dropped never asserted.
REQ-034 Stimulus 55 55 AA 11 (tlast) followed by 55 D5 7E (tlast) -> exactly one frame_dropped pulse, then a single output byte 7E with tlast.
REQ-035 Stimulus 55 D5 (tlast on D5) -> no output and one frame_dropped pulse; same with MIN_PREAMBLE_BYTES = 2 and input D5 after one 55 -> no output and one frame_dropped pulse.
REQ-036 Stimulus of 200 random frames of 1-24 payload bytes with random maxis_tready, comparing against a queue model -> all bytes and tlast match in order, and input tuser appears on the last byte.
REQ-037 With the macro on, stimulus 55x7 D5 01 02 03 04 CD FB 3C B6 (tlast) -> output 01 02 03 04 with tlast on 04 and tuser 0; flipping bit 0 of B6 -> tuser 1.
REQ-038 Asserting reset during payload byte 3 of a 10-byte frame -> all outputs are 0 within the same cycle, and the next clean frame is received intact.
